// File: rtl/hdmi_infoframe_pkg.sv
// Shared constants, types and helpers for the HDMI InfoFrame parsers.
package hdmi_infoframe_pkg;

    // Packet framing: three header bytes followed by PB0..PB27
    localparam logic [7:0] AVI_TYPE     = 8'h82;
    localparam int         PKT_BYTES    = 31;
    localparam int         HDR_BYTES    = 3;
    localparam logic [4:0] LAST_IDX     = 5'(PKT_BYTES - 1);
    localparam logic [4:0] HDR_LAST_IDX = 5'(HDR_BYTES - 1);
    localparam logic [4:0] PB0_IDX      = 5'(HDR_BYTES);

    // Error codes reported on err_code
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_VERSION  = 3'd1;
    localparam logic [2:0] ERR_LENGTH   = 3'd2;
    localparam logic [2:0] ERR_CHECKSUM = 3'd3;
    localparam logic [2:0] ERR_RESERVED = 3'd4;
    localparam logic [2:0] ERR_TRUNC    = 3'd5;

    // AVI field bit positions (same as the generator)
    localparam int PB1_Y_MSB   = 6;
    localparam int PB1_Y_LSB   = 5;
    localparam int PB4_VIC_MSB = 6;
    localparam int PB5_PR_MSB  = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_BODY   = 3'd2,
        ST_SKIP   = 3'd3,
        ST_DONE   = 3'd4
    } parse_state_e;

    // Highest-priority error among the per-frame fault flags
    function automatic logic [2:0] err_select(input logic ver_bad, input logic len_bad,
                                              input logic cks_bad, input logic rsv_bad);
        logic [2:0] code;
        if (ver_bad) begin
            code = ERR_VERSION;
        end else if (len_bad) begin
            code = ERR_LENGTH;
        end else if (cks_bad) begin
            code = ERR_CHECKSUM;
        end else if (rsv_bad) begin
            code = ERR_RESERVED;
        end else begin
            code = ERR_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/infoframe_checksum_acc.sv
// 8-bit modulo-256 InfoFrame checksum accumulator with clear/load/add and zero flag.
module infoframe_checksum_acc (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  logic       add,
    input  logic [7:0] din,
    output logic [7:0] sum,
    output logic       zero
);

    logic [7:0] sum_q, sum_d;

    // Next accumulator value: clear beats load beats add
    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = 8'd0;
        end else if (load) begin
            sum_d = din;
        end else if (add) begin
            sum_d = sum_q + din;
        end else begin
            sum_d = sum_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= 8'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum  = sum_q;
    assign zero = (sum_q == 8'd0);

endmodule

// File: rtl/avi_info_frame_parser.sv
// AVI InfoFrame receiver: filters, validates and latches AVI fields from a packet byte stream.
module avi_info_frame_parser
    import hdmi_infoframe_pkg::*;
#(
    parameter logic [7:0] EXPECTED_VERSION = 8'd2,
    parameter logic [4:0] EXPECTED_LENGTH  = 5'd13,
    parameter logic       CHECK_RESERVED   = 1'b0
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       pkt_start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       avi_valid,
    output logic       avi_update,
    output logic [7:0] avi_pb1,
    output logic [7:0] avi_pb2,
    output logic [7:0] avi_pb3,
    output logic [7:0] avi_pb4,
    output logic [7:0] avi_pb5,
    output logic [1:0] video_format,
    output logic [6:0] vic,
    output logic [3:0] pixel_repetition,
    output logic       err_pulse,
    output logic [2:0] err_code
);

    parse_state_e    state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    logic            ver_bad_q, ver_bad_d, len_bad_q, len_bad_d, rsv_bad_q, rsv_bad_d;
    logic [4:0][7:0] shadow_q, shadow_d;
    logic [4:0][7:0] pb_q, pb_d;
    logic            avi_valid_q, avi_valid_d, avi_update_q, avi_update_d;
    logic            err_pulse_q, err_pulse_d;
    logic [2:0]      err_code_q, err_code_d;

    logic            acc_clr_s, acc_load_s, acc_add_s, acc_zero_s;
    logic [7:0]      acc_sum_s, cks_sum_s;
    logic            start_s, is_avi_s, last_s, in_span_s, rsv_byte_bad_s, cks_bad_s;
    logic [4:0]      pb_num_s;
    logic [2:0]      final_err_s;

    // A qualified pkt_start always restarts parsing, whatever the state
    assign start_s        = byte_valid & pkt_start;
    assign is_avi_s       = (byte_data == AVI_TYPE);
    assign last_s         = (idx_q == LAST_IDX);
    assign pb_num_s       = idx_q - PB0_IDX;
    assign in_span_s      = (pb_num_s <= EXPECTED_LENGTH);
    assign rsv_byte_bad_s = CHECK_RESERVED & ~in_span_s & (byte_data != 8'd0);
    // The last byte may still lie inside the checksum span, so fold it in here
    assign cks_sum_s      = acc_sum_s + byte_data;
    assign cks_bad_s      = in_span_s ? (cks_sum_s != 8'd0) : ~acc_zero_s;
    assign final_err_s    = err_select(ver_bad_q, len_bad_q, cks_bad_s, rsv_bad_q | rsv_byte_bad_s);

    infoframe_checksum_acc u_acc (
        .clk   (clk_pixel),
        .reset (reset),
        .clr   (acc_clr_s),
        .load  (acc_load_s),
        .add   (acc_add_s),
        .din   (byte_data),
        .sum   (acc_sum_s),
        .zero  (acc_zero_s)
    );

    // State register
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (start_s) begin
            state_d = is_avi_s ? ST_HEADER : ST_SKIP;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_HEADER: state_d = (byte_valid && idx_q == HDR_LAST_IDX) ? ST_BODY : ST_HEADER;
                ST_BODY:   state_d = (byte_valid && last_s) ? ST_DONE : ST_BODY;
                ST_SKIP:   state_d = (byte_valid && last_s) ? ST_IDLE : ST_SKIP;
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and output decisions; results land in registers one cycle after the byte
    always_comb begin
        idx_d        = idx_q;
        ver_bad_d    = ver_bad_q;
        len_bad_d    = len_bad_q;
        rsv_bad_d    = rsv_bad_q;
        shadow_d     = shadow_q;
        pb_d         = pb_q;
        avi_valid_d  = avi_valid_q;
        avi_update_d = 1'b0;
        err_pulse_d  = 1'b0;
        err_code_d   = err_code_q;
        acc_clr_s    = 1'b0;
        acc_load_s   = 1'b0;
        acc_add_s    = 1'b0;
        if (start_s) begin
            idx_d      = 5'd1;
            ver_bad_d  = 1'b0;
            len_bad_d  = 1'b0;
            rsv_bad_d  = 1'b0;
            acc_load_s = is_avi_s;
            acc_clr_s  = ~is_avi_s;
            // Abandoning a partly received AVI frame is reported; other packets are not
            if (state_q == ST_HEADER || state_q == ST_BODY) begin
                err_pulse_d = 1'b1;
                err_code_d  = ERR_TRUNC;
            end else begin
                err_pulse_d = 1'b0;
            end
        end else if (byte_valid) begin
            case (state_q)
                ST_HEADER: begin
                    idx_d     = idx_q + 5'd1;
                    acc_add_s = 1'b1;
                    if (idx_q == 5'd1) begin
                        ver_bad_d = (byte_data != EXPECTED_VERSION);
                    end else begin
                        len_bad_d = (byte_data[4:0] != EXPECTED_LENGTH);
                    end
                end
                ST_BODY: begin
                    acc_add_s = in_span_s;
                    rsv_bad_d = rsv_bad_q | rsv_byte_bad_s;
                    if (pb_num_s >= 5'd1 && pb_num_s <= 5'd5) begin
                        shadow_d[pb_num_s[2:0] - 3'd1] = byte_data;
                    end else begin
                        shadow_d = shadow_q;
                    end
                    if (last_s) begin
                        idx_d = 5'd0;
                        if (final_err_s == ERR_NONE) begin
                            pb_d         = shadow_q;
                            avi_valid_d  = 1'b1;
                            avi_update_d = 1'b1;
                        end else begin
                            err_pulse_d = 1'b1;
                            err_code_d  = final_err_s;
                        end
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
                ST_SKIP: idx_d = last_s ? 5'd0 : (idx_q + 5'd1);
                default: idx_d = idx_q;
            endcase
        end else begin
            idx_d = idx_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            idx_q        <= 5'd0;
            ver_bad_q    <= 1'b0;
            len_bad_q    <= 1'b0;
            rsv_bad_q    <= 1'b0;
            shadow_q     <= '0;
            pb_q         <= '0;
            avi_valid_q  <= 1'b0;
            avi_update_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            idx_q        <= idx_d;
            ver_bad_q    <= ver_bad_d;
            len_bad_q    <= len_bad_d;
            rsv_bad_q    <= rsv_bad_d;
            shadow_q     <= shadow_d;
            pb_q         <= pb_d;
            avi_valid_q  <= avi_valid_d;
            avi_update_q <= avi_update_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
        end
    end

    assign avi_valid        = avi_valid_q;
    assign avi_update       = avi_update_q;
    assign avi_pb1          = pb_q[0];
    assign avi_pb2          = pb_q[1];
    assign avi_pb3          = pb_q[2];
    assign avi_pb4          = pb_q[3];
    assign avi_pb5          = pb_q[4];
    assign video_format     = pb_q[0][PB1_Y_MSB:PB1_Y_LSB];
    assign vic              = pb_q[3][PB4_VIC_MSB:0];
    assign pixel_repetition = pb_q[4][PB5_PR_MSB:0];
    assign err_pulse        = err_pulse_q;
    assign err_code         = err_code_q;

endmodule

// File: tb/tb_avi_info_frame_parser.sv
// Self-checking bench: directed and random packets against a frame-level reference model.
module tb_avi_info_frame_parser;

    logic       clk_pixel = 1'b0;
    logic       reset;
    logic       pkt_start;
    logic       byte_valid;
    logic [7:0] byte_data;

    // Instance a: CHECK_RESERVED=0, instance b: CHECK_RESERVED=1, same stimulus
    logic       valid_a, upd_a, errp_a, valid_b, upd_b, errp_b;
    logic [7:0] pb1_a, pb2_a, pb3_a, pb4_a, pb5_a, pb1_b, pb2_b, pb3_b, pb4_b, pb5_b;
    logic [1:0] vf_a, vf_b;
    logic [6:0] vic_a, vic_b;
    logic [3:0] pr_a, pr_b;
    logic [2:0] ec_a, ec_b;

    avi_info_frame_parser dut_a (
        .clk_pixel(clk_pixel), .reset(reset), .pkt_start(pkt_start), .byte_valid(byte_valid),
        .byte_data(byte_data), .avi_valid(valid_a), .avi_update(upd_a), .avi_pb1(pb1_a),
        .avi_pb2(pb2_a), .avi_pb3(pb3_a), .avi_pb4(pb4_a), .avi_pb5(pb5_a),
        .video_format(vf_a), .vic(vic_a), .pixel_repetition(pr_a), .err_pulse(errp_a),
        .err_code(ec_a));

    avi_info_frame_parser #(.CHECK_RESERVED(1'b1)) dut_b (
        .clk_pixel(clk_pixel), .reset(reset), .pkt_start(pkt_start), .byte_valid(byte_valid),
        .byte_data(byte_data), .avi_valid(valid_b), .avi_update(upd_b), .avi_pb1(pb1_b),
        .avi_pb2(pb2_b), .avi_pb3(pb3_b), .avi_pb4(pb4_b), .avi_pb5(pb5_b),
        .video_format(vf_b), .vic(vic_b), .pixel_repetition(pr_b), .err_pulse(errp_b),
        .err_code(ec_b));

    always #5 clk_pixel = ~clk_pixel;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0]  frm [0:30];
    logic        exp_valid [2];
    logic [2:0]  exp_code  [2];
    logic [39:0] exp_pbs   [2];
    int          exp_upd   [2];
    int          exp_err   [2];
    bit          pending_trunc;

    // Pulse counters, sampled mid-cycle
    int seen_upd_a = 0, seen_upd_b = 0, seen_err_a = 0, seen_err_b = 0;
    always @(negedge clk_pixel) begin
        seen_upd_a <= seen_upd_a + int'(upd_a);
        seen_upd_b <= seen_upd_b + int'(upd_b);
        seen_err_a <= seen_err_a + int'(errp_a);
        seen_err_b <= seen_err_b + int'(errp_b);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outcome of a complete frame: -1 not AVI, 0 good, else error code
    function automatic int predict(input bit rsv);
        logic [7:0] s;
        s = 8'd0;
        if (frm[0] != 8'h82) return -1;
        if (frm[1] != 8'd2) return 1;
        if (frm[2][4:0] != 5'd13) return 2;
        for (int i = 0; i < 17; i++) s = s + frm[i];
        if (s != 8'd0) return 3;
        if (rsv) begin
            for (int i = 17; i < 31; i++) if (frm[i] != 8'd0) return 4;
        end
        return 0;
    endfunction

    task automatic fix_checksum();
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 17; i++) if (i != 3) s = s + frm[i];
        frm[3] = 8'd0 - s;
    endtask

    task automatic build_good(input bit rnd);
        frm[0] = 8'h82;
        frm[1] = 8'h02;
        frm[2] = rnd ? {3'($urandom), 5'd13} : 8'h0D;
        frm[4] = rnd ? 8'($urandom) : 8'h20;
        frm[5] = rnd ? 8'($urandom) : 8'h08;
        frm[6] = rnd ? 8'($urandom) : 8'h00;
        frm[7] = rnd ? 8'($urandom) : 8'h04;
        frm[8] = rnd ? 8'($urandom) : 8'h00;
        for (int i = 9; i < 17; i++) frm[i] = rnd ? 8'($urandom) : 8'h00;
        for (int i = 17; i < 31; i++) frm[i] = 8'h00;
        fix_checksum();
    endtask

    task automatic check_state(input int d, input string tag);
        logic v; logic [39:0] pb; logic [1:0] vf; logic [6:0] vc; logic [3:0] pr; logic [2:0] ec;
        if (d == 0) begin
            v = valid_a; pb = {pb1_a, pb2_a, pb3_a, pb4_a, pb5_a}; vf = vf_a; vc = vic_a; pr = pr_a; ec = ec_a;
        end else begin
            v = valid_b; pb = {pb1_b, pb2_b, pb3_b, pb4_b, pb5_b}; vf = vf_b; vc = vic_b; pr = pr_b; ec = ec_b;
        end
        chk($sformatf("%s[%0d] avi_valid", tag, d), 64'(v), 64'(exp_valid[d]));
        chk($sformatf("%s[%0d] avi_pb1..5", tag, d), 64'(pb), 64'(exp_pbs[d]));
        chk($sformatf("%s[%0d] video_format", tag, d), 64'(vf), 64'(exp_pbs[d][38:37]));
        chk($sformatf("%s[%0d] vic", tag, d), 64'(vc), 64'(exp_pbs[d][14:8]));
        chk($sformatf("%s[%0d] pixel_rep", tag, d), 64'(pr), 64'(exp_pbs[d][3:0]));
        chk($sformatf("%s[%0d] err_code", tag, d), 64'(ec), 64'(exp_code[d]));
    endtask

    task automatic check_counts(input string tag);
        chk({tag, " upd count a"}, 64'(seen_upd_a), 64'(exp_upd[0]));
        chk({tag, " upd count b"}, 64'(seen_upd_b), 64'(exp_upd[1]));
        chk({tag, " err count a"}, 64'(seen_err_a), 64'(exp_err[0]));
        chk({tag, " err count b"}, 64'(seen_err_b), 64'(exp_err[1]));
    endtask

    task automatic idle(input int k);
        byte_valid = 1'b0;
        pkt_start  = 1'b0;
        repeat (k) begin
            @(posedge clk_pixel); #1;
        end
    endtask

    // One accepted byte, optionally preceded by idle cycles carrying junk
    task automatic put_byte(input logic [7:0] b, input logic st, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                pkt_start  = 1'($urandom);
                byte_data  = 8'($urandom);
                @(posedge clk_pixel); #1;
            end
        end
        byte_valid = 1'b1;
        pkt_start  = st;
        byte_data  = b;
        @(posedge clk_pixel); #1;
        byte_valid = 1'b0;
        pkt_start  = 1'b0;
    endtask

    // Send frm[0..n-1]; n < 31 leaves the packet to be abandoned by the next one
    task automatic run_frame(input int n, input bit gaps, input bit tail_idle, input string tag);
        int code [2];
        code[0] = predict(1'b0);
        code[1] = predict(1'b1);
        for (int i = 0; i < n; i++) begin
            put_byte(frm[i], (i == 0), gaps);
            if (i == 0) begin
                chk({tag, " trunc pulse a"}, 64'(errp_a), 64'(pending_trunc));
                chk({tag, " trunc pulse b"}, 64'(errp_b), 64'(pending_trunc));
                if (pending_trunc) begin
                    for (int d = 0; d < 2; d++) begin
                        exp_code[d] = 3'd5;
                        exp_err[d]++;
                        check_state(d, {tag, " trunc"});
                    end
                end
                pending_trunc = 1'b0;
            end
        end
        if (n == 31) begin
            for (int d = 0; d < 2; d++) begin
                if (code[d] == 0) begin
                    exp_valid[d] = 1'b1;
                    exp_pbs[d]   = {frm[4], frm[5], frm[6], frm[7], frm[8]};
                    exp_upd[d]++;
                end else if (code[d] > 0) begin
                    exp_code[d] = 3'(code[d]);
                    exp_err[d]++;
                end
            end
            chk({tag, " avi_update a"}, 64'(upd_a), 64'(code[0] == 0));
            chk({tag, " err_pulse a"}, 64'(errp_a), 64'(code[0] > 0));
            chk({tag, " avi_update b"}, 64'(upd_b), 64'(code[1] == 0));
            chk({tag, " err_pulse b"}, 64'(errp_b), 64'(code[1] > 0));
            check_state(0, tag);
            check_state(1, tag);
        end else if (frm[0] == 8'h82) begin
            pending_trunc = 1'b1;
        end
        if (tail_idle) begin
            idle(1);
            check_counts(tag);
        end
    endtask

    initial begin
        reset      = 1'b1;
        pkt_start  = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        pending_trunc = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_valid[d] = 1'b0; exp_code[d] = 3'd0; exp_pbs[d] = 40'd0;
            exp_upd[d] = 0; exp_err[d] = 0;
        end
        repeat (3) @(posedge clk_pixel);
        #1;
        reset = 1'b0;
        check_state(0, "reset");
        check_state(1, "reset");
        chk("reset avi_update", 64'(upd_a), 64'd0);
        chk("reset err_pulse", 64'(errp_a), 64'd0);

        // Default generator frame
        build_good(1'b0);
        run_frame(31, 1'b0, 1'b1, "default");
        chk("default video_format", 64'(vf_a), 64'd1);
        chk("default vic", 64'(vic_a), 64'd4);
        chk("default pb1", 64'(pb1_a), 64'h20);

        // Bad checksum
        build_good(1'b0);
        frm[3] = 8'h44;
        run_frame(31, 1'b0, 1'b1, "checksum");
        chk("checksum code", 64'(ec_a), 64'd3);

        // Version beats checksum
        build_good(1'b0);
        frm[1] = 8'h03;
        run_frame(31, 1'b0, 1'b1, "version");
        chk("version code", 64'(ec_a), 64'd1);

        // Length mismatch
        build_good(1'b0);
        frm[2] = 8'h0E;
        run_frame(31, 1'b0, 1'b1, "length");
        chk("length code", 64'(ec_a), 64'd2);

        // Audio InfoFrame is ignored, then a good AVI frame
        for (int i = 0; i < 31; i++) frm[i] = 8'($urandom);
        frm[0] = 8'h84;
        run_frame(31, 1'b0, 1'b1, "audio");
        build_good(1'b0);
        run_frame(31, 1'b0, 1'b1, "after_audio");

        // Abandon at index 12, then a full frame; without and with gaps
        for (int g = 0; g < 2; g++) begin
            build_good(1'b0);
            run_frame(12, g[0], 1'b1, "trunc12");
            build_good(1'b1);
            run_frame(31, g[0], 1'b1, "after_trunc");
        end

        // Nonzero PB20: only the reserved-checking instance rejects it
        build_good(1'b0);
        frm[23] = 8'h01;
        run_frame(31, 1'b0, 1'b1, "reserved");
        chk("reserved code b", 64'(ec_b), 64'd4);

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            int kind;
            int n;
            kind = int'($urandom_range(0, 9));
            n = 31;
            build_good(1'b1);
            case (kind)
                0: begin
                    for (int i = 0; i < 31; i++) frm[i] = 8'($urandom);
                    if (frm[0] == 8'h82) frm[0] = 8'h84;
                end
                1: frm[1] = 8'h03 + 8'($urandom_range(0, 200));
                2: frm[2][4:0] = 5'd14 + 5'($urandom_range(0, 17));
                3: frm[3] = frm[3] + 8'($urandom_range(1, 255));
                4: frm[17 + $urandom_range(0, 13)] = 8'($urandom_range(1, 255));
                5: n = int'($urandom_range(1, 30));
                default: n = 31;
            endcase
            run_frame(n, 1'($urandom), ((n < 31) ? 1'b1 : 1'($urandom)), $sformatf("rand%0d", k));
        end
        build_good(1'b1);
        run_frame(31, 1'b1, 1'b1, "rand_final");

        // Reset in the middle of an AVI frame: discarded silently
        build_good(1'b1);
        run_frame(10, 1'b1, 1'b1, "pre_reset");
        reset = 1'b1;
        repeat (2) @(posedge clk_pixel);
        #1;
        reset = 1'b0;
        pending_trunc = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_valid[d] = 1'b0; exp_code[d] = 3'd0; exp_pbs[d] = 40'd0;
        end
        check_state(0, "mid_reset");
        check_state(1, "mid_reset");
        idle(1);
        check_counts("mid_reset");
        build_good(1'b0);
        run_frame(31, 1'b0, 1'b1, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
